// File: rtl/lane_rr_arbiter.sv
// Four-lane round-robin arbiter feeding a one-entry valid/ready output register.
// Define LANE_ARB_FIXED_PRIO_EN for fixed priority (lane 0 highest) instead of round-robin.
module lane_rr_arbiter #(
  parameter int unsigned DW      = 4,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned RST_PTR = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [3:0]    i_req,
  input  logic [DW-1:0] i_d0,
  input  logic [DW-1:0] i_d1,
  input  logic [DW-1:0] i_d2,
  input  logic [DW-1:0] i_d3,
  output logic [3:0]    o_ack,
  output logic [1:0]    o_sel,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  output logic [1:0]    o_out_lane,
  input  logic          i_out_ready,
  output logic          o_drop
);

  localparam logic       S_IDLE = 1'b0;
  localparam logic       S_HOLD = 1'b1;
  localparam logic [1:0] PTR_INIT = 2'(RST_PTR);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic            r_state;
  logic [1:0]      r_ptr;
  logic [TO_W-1:0] r_cnt;
  logic [1:0]      r_sel;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_lane;

  logic [1:0]      w_win;
  logic            w_hit;
  logic            w_load;
  logic [DW-1:0]   w_data;

`ifdef LANE_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (i_req[k]) w_win = 2'(k);
    end
  end
`else
  logic [1:0] w_idx;
  logic       w_seen;

  // Scan starts at the pointer so the last winner has lowest priority next time.
  always_comb begin
    w_win  = r_ptr;
    w_seen = 1'b0;
    w_idx  = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_seen && i_req[w_idx]) begin
        w_win  = w_idx;
        w_seen = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_data = i_d0;
    case (w_win)
      2'd0: w_data = i_d0;
      2'd1: w_data = i_d1;
      2'd2: w_data = i_d2;
      2'd3: w_data = i_d3;
    endcase
  end

  always_comb begin
    w_hit = 1'b0;
    if (TIMEOUT != 0) begin
      w_hit = (r_state == S_HOLD) && (r_cnt == TO_LAST) && !i_out_ready;
    end
  end

  // Gating with reset keeps ack and drop quiet during the reset cycle.
  assign w_load      = !i_rst && (|i_req) && ((r_state == S_IDLE) || i_out_ready || w_hit);
  assign o_ack       = w_load ? (4'b0001 << w_win) : 4'b0000;
  assign o_sel       = w_load ? w_win : r_sel;
  assign o_drop      = w_hit && !i_rst;
  assign o_out_valid = (r_state == S_HOLD);
  assign o_out_data  = r_data;
  assign o_out_lane  = r_lane;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_INIT;
      r_cnt   <= '0;
      r_sel   <= 2'd0;
      r_data  <= '0;
      r_lane  <= 2'd0;
    end else if (w_load) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_sel   <= w_win;
      r_data  <= w_data;
      r_lane  <= w_win;
`ifndef LANE_ARB_FIXED_PRIO_EN
      r_ptr   <= w_win + 2'd1;
`endif
    end else if (r_state == S_HOLD) begin
      if (i_out_ready || w_hit) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (TIMEOUT != 0) begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

endmodule
